// File: rtl/cascade_pkg.sv
// rtl/cascade_pkg.sv - shared state encoding and sat-add width constants for the cascade stage logic
package cascade_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CMP   = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // One guard bit is enough to detect overflow of a signed add with W_A >= W_B.
  localparam int SAT_GUARD  = 1;
  localparam int W_LEAF_DEF = 16;
  localparam int W_ACC_DEF  = 20;

endpackage

// File: rtl/dti.sv
// rtl/dti.sv - valid/ready/data stream interface with producer and consumer views
interface dti #(parameter int W = 1) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);

endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed adder that clamps to the W_A signed range instead of wrapping
module sat_add
  import cascade_pkg::*;
#(
  parameter int W_A = W_ACC_DEF,
  parameter int W_B = W_LEAF_DEF
) (
  input  logic signed [W_A-1:0] a_i,
  input  logic signed [W_B-1:0] b_i,
  output logic signed [W_A-1:0] sum_o
);

  localparam int WS = W_A + SAT_GUARD;

  logic signed [WS-1:0] a_ext;
  logic signed [WS-1:0] b_ext;
  logic signed [WS-1:0] full;

  assign a_ext = {{(WS-W_A){a_i[W_A-1]}}, a_i};
  assign b_ext = {{(WS-W_B){b_i[W_B-1]}}, b_i};
  assign full  = a_ext + b_ext;

  // Top two bits disagree only when the true sum left the W_A range.
  always_comb begin
    sum_o = full[W_A-1:0];
    if (full[WS-1] != full[WS-2]) begin
      sum_o = full[WS-1] ? {1'b1, {(W_A-1){1'b0}}} : {1'b0, {(W_A-1){1'b1}}};
    end
  end

endmodule

// File: rtl/stage_sum_acc.sv
// rtl/stage_sum_acc.sv - per-stage leaf accumulator with threshold compare and {final, pass} result
module stage_sum_acc
  import cascade_pkg::*;
#(
  parameter int W_LEAF   = W_LEAF_DEF,
  parameter int W_ACC    = W_ACC_DEF,
  parameter int N_STAGES = 25
) (
  input logic  clk,
  input logic  rst,
  dti.consumer leaf0_if,
  dti.consumer leaf1_if,
  dti.consumer feat_if,
  dti.consumer thr_if,
  dti.producer res_if
);

  localparam int CW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CW-1:0] LAST_STAGE = CW'(N_STAGES - 1);

  state_e                  state_q;
  logic signed [W_ACC-1:0] acc_q;
  logic [CW-1:0]           cnt_q;
  logic                    pass_q;
  logic                    final_q;

  logic signed [W_LEAF-1:0] leaf_val;
  logic signed [W_ACC-1:0]  acc_sum;
  logic signed [W_ACC-1:0]  thr_val;
  logic                     join_go;
  logic                     thr_go;
  logic                     res_go;
  logic                     cmp_pass;

  // Readies are gated by rst so nothing handshakes while reset is held.
  assign join_go = rst && (state_q == ST_ACCUM) &&
                   leaf0_if.valid && leaf1_if.valid && feat_if.valid;
  assign leaf0_if.ready = join_go;
  assign leaf1_if.ready = join_go;
  assign feat_if.ready  = join_go;

  assign thr_if.ready = rst && (state_q == ST_CMP);
  assign thr_go       = thr_if.ready && thr_if.valid;
  assign thr_val      = thr_if.data;
  assign cmp_pass     = (acc_q >= thr_val);

  assign res_if.valid = (state_q == ST_OUT);
  assign res_if.data  = {final_q, pass_q};
  assign res_go       = res_if.valid && res_if.ready;

  assign leaf_val = feat_if.data[0] ? leaf1_if.data : leaf0_if.data;

  sat_add #(.W_A(W_ACC), .W_B(W_LEAF)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (leaf_val),
    .sum_o (acc_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (join_go) begin
            acc_q <= acc_sum;
            if (feat_if.data[1]) state_q <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (thr_go) begin
            pass_q  <= cmp_pass;
            final_q <= !cmp_pass || (cnt_q == LAST_STAGE);
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_go) begin
            acc_q   <= '0;
            cnt_q   <= final_q ? '0 : cnt_q + 1'b1;
            state_q <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sum_acc.sv
// tb/tb_stage_sum_acc.sv - scoreboard bench for stage_sum_acc with directed stage vectors
module tb_stage_sum_acc;
  import cascade_pkg::*;

  localparam int WL = 16;
  localparam int WA = 20;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dti #(.W(WL)) leaf0_if ();
  dti #(.W(WL)) leaf1_if ();
  dti #(.W(2))  feat_if ();
  dti #(.W(WA)) thr_if ();
  dti #(.W(2))  res_if ();

  stage_sum_acc #(.W_LEAF(WL), .W_ACC(WA), .N_STAGES(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .leaf0_if (leaf0_if),
    .leaf1_if (leaf1_if),
    .feat_if  (feat_if),
    .thr_if   (thr_if),
    .res_if   (res_if)
  );

  int tests   = 0;
  int fails   = 0;
  int rx_cnt  = 0;
  int exp_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  always @(negedge clk) begin
    if (rst && res_if.valid && res_if.ready) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_res: got %0d expected no word", res_if.data);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_word", longint'(res_if.data), longint'(mon_e));
      end
    end
  end

  task automatic feat(input logic sel, input logic last,
                      input logic signed [WL-1:0] l0, input logic signed [WL-1:0] l1);
    int n = 0;
    leaf0_if.data  = l0;
    leaf1_if.data  = l1;
    feat_if.data   = {last, sel};
    leaf0_if.valid = 1'b1;
    leaf1_if.valid = 1'b1;
    feat_if.valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!leaf0_if.ready && n < 100);
    if (!leaf0_if.ready) timeout("join_timeout");
    @(posedge clk);
    #1;
    leaf0_if.valid = 1'b0;
    leaf1_if.valid = 1'b0;
    feat_if.valid  = 1'b0;
  endtask

  task automatic thr(input logic signed [WA-1:0] t, input logic [1:0] e, input bit push);
    int n = 0;
    if (push) begin
      exp_q.push_back(e);
      exp_cnt++;
    end
    thr_if.data  = t;
    thr_if.valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!thr_if.ready && n < 100);
    if (!thr_if.ready) timeout("thr_timeout");
    @(posedge clk);
    #1;
    thr_if.valid = 1'b0;
  endtask

  task automatic wait_rx();
    int n = 0;
    while (rx_cnt < exp_cnt && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (rx_cnt < exp_cnt) timeout("res_timeout");
  endtask

  initial begin
    leaf0_if.valid = 1'b0; leaf0_if.data = '0;
    leaf1_if.valid = 1'b0; leaf1_if.data = '0;
    feat_if.valid  = 1'b0; feat_if.data  = '0;
    thr_if.valid   = 1'b0; thr_if.data   = '0;
    res_if.ready   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", res_if.valid, 0);
    check("rst_acc", dut.acc_q, 0);
    check("rst_cnt", dut.cnt_q, 0);
    check("rst_state", dut.state_q, ST_ACCUM);
    check("rst_pass_final", {dut.final_q, dut.pass_q}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Stage 0: 10 - 4 + 10 = 16 against 15 -> pass, not final
    feat(1'b0, 1'b0, 16'sd10, -16'sd4);
    feat(1'b1, 1'b0, 16'sd10, -16'sd4);
    feat(1'b0, 1'b1, 16'sd10, -16'sd4);
    check("acc_16", dut.acc_q, 16);
    thr(20'sd15, 2'b01, 1'b1);
    wait_rx();

    // Stage 1: same sum against 17 -> fail, final, counter wraps to 0
    feat(1'b0, 1'b0, 16'sd10, -16'sd4);
    feat(1'b1, 1'b0, 16'sd10, -16'sd4);
    feat(1'b0, 1'b1, 16'sd10, -16'sd4);
    thr(20'sd17, 2'b10, 1'b1);
    wait_rx();
    check("cnt_after_fail", dut.cnt_q, 0);

    // Two passing stages: last stage is final
    for (int s = 0; s < 2; s++) begin
      feat(1'b0, 1'b0, 16'sd10, -16'sd4);
      feat(1'b1, 1'b0, 16'sd10, -16'sd4);
      feat(1'b0, 1'b1, 16'sd10, -16'sd4);
      thr(20'sd15, (s == 0) ? 2'b01 : 2'b11, 1'b1);
      wait_rx();
    end
    check("cnt_after_last", dut.cnt_q, 0);

    // Positive saturation: 40 * 32767 clamps at 524287
    for (int i = 0; i < 40; i++) feat(1'b1, (i == 39), 16'sd0, 16'sd32767);
    check("acc_sat_pos", dut.acc_q, 524287);
    thr(20'sd524287, 2'b01, 1'b1);
    wait_rx();

    // Negative saturation: 40 * -32768 clamps at -524288
    for (int i = 0; i < 40; i++) feat(1'b0, (i == 39), -16'sd32768, 16'sd0);
    check("acc_sat_neg", dut.acc_q, -524288);
    thr(-20'sd524288, 2'b11, 1'b1);
    wait_rx();

    // Partial valids: leaf1 withheld, nothing consumed
    leaf0_if.data  = 16'sd5;
    feat_if.data   = 2'b10;
    leaf0_if.valid = 1'b1;
    feat_if.valid  = 1'b1;
    leaf1_if.valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("partial_ready", {leaf0_if.ready, leaf1_if.ready, feat_if.ready}, 0);
      check("partial_acc", dut.acc_q, 0);
    end
    @(posedge clk);
    #1;
    // Single-feature stage, equality counts as pass
    feat(1'b0, 1'b1, 16'sd5, 16'sd0);
    thr(20'sd5, 2'b01, 1'b1);
    wait_rx();

    // Minimum latency with threshold already valid
    thr_if.data  = 20'sd100;
    thr_if.valid = 1'b1;
    exp_q.push_back(2'b10);
    exp_cnt++;
    feat(1'b1, 1'b1, 16'sd0, 16'sd7);
    @(negedge clk);
    check("lat_cmp_valid", res_if.valid, 0);
    @(negedge clk);
    check("lat_out_valid", res_if.valid, 1);
    @(posedge clk);
    #1;
    thr_if.valid = 1'b0;
    wait_rx();

    // Backpressure: result held stable for 4 cycles
    res_if.ready = 1'b0;
    feat(1'b0, 1'b1, 16'sd1, 16'sd0);
    thr(20'sd0, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", res_if.valid, 1);
      check("stall_data", res_if.data, 2'b01);
    end
    @(posedge clk);
    #1;
    res_if.ready = 1'b1;
    wait_rx();

    // Reset in OUT discards the pending word and the stage counter
    res_if.ready = 1'b0;
    feat(1'b0, 1'b1, 16'sd2, 16'sd0);
    thr(20'sd9, 2'b00, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", res_if.valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    leaf0_if.valid = 1'b1;
    leaf1_if.valid = 1'b1;
    feat_if.valid  = 1'b1;
    thr_if.valid   = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", res_if.valid, 0);
    check("rst_mid_readies", {leaf0_if.ready, leaf1_if.ready, feat_if.ready, thr_if.ready}, 0);
    check("rst_mid_acc", dut.acc_q, 0);
    check("rst_mid_cnt", dut.cnt_q, 0);
    res_if.ready = 1'b1;
    @(posedge clk);
    #1;
    leaf0_if.valid = 1'b0;
    leaf1_if.valid = 1'b0;
    feat_if.valid  = 1'b0;
    thr_if.valid   = 1'b0;
    rst = 1'b1;

    // Fresh stage 0 after reset: pass is non-final
    feat(1'b0, 1'b1, 16'sd3, 16'sd0);
    thr(20'sd3, 2'b01, 1'b1);
    wait_rx();

    repeat (3) @(posedge clk);
    check("rx_count", rx_cnt, exp_cnt);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
